// File: rtl/cache_arb_pkg.sv
// Shared types and helpers for the L1-to-L2 line-port arbiter.
//   arb_state_t : arbiter FSM state (IDLE waits for requests, BUSY owns memory)
//   ADDR_W      : line address width
//   clog2_min1  : index width for a client count, never below 1 bit
package cache_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int unsigned ADDR_W = 32;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cache_arbiter_rr_picker.sv
// Combinational winner selection for the arbiter.
//   req_i        : per-client request vector
//   last_i       : index of the last client that completed a transaction
//   fixed_prio_i : 1 = highest requesting index wins, 0 = round-robin after last_i
//   winner_o     : chosen client index (0 when nothing requests)
//   any_o        : at least one client requests
module rr_picker #(
  parameter int unsigned N = 2,
  parameter int unsigned W = 1
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] last_i,
  input  logic         fixed_prio_i,
  output logic [W-1:0] winner_o,
  output logic         any_o
);

  logic [2*N-1:0] dbl;

  // Round-robin: duplicate the request vector and take the lowest set bit
  // strictly above last_i; the upper copy supplies the wrap-around.
  always_comb begin
    dbl      = {req_i, req_i};
    winner_o = '0;
    any_o    = |req_i;
    if (fixed_prio_i) begin
      for (int j = 0; j < int'(N); j++) begin
        if (req_i[j]) winner_o = W'(j);
      end
    end else begin
      for (int j = int'(2 * N) - 1; j >= 0; j--) begin
        if (dbl[j] && (j > int'(last_i))) begin
          winner_o = (j >= int'(N)) ? W'(j - int'(N)) : W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/cache_arbiter_rr.sv
// N-client arbiter between L1 caches and a single L2/memory line port.
// A grant is registered per transaction and held until mem_resp.
//   clk, rst                    : clock, synchronous active-high reset
//   cl_read/cl_write            : per-client line requests
//   cl_address/cl_wdata         : per-client address and write line
//   cl_resp                     : one-hot completion pulse to the granted client
//   cl_rdata                    : memory read line, broadcast to all clients
//   mem_read/mem_write          : forwarded request of the granted client
//   mem_address/mem_wdata       : forwarded address and write line
//   mem_resp/mem_rdata          : memory completion and read line
module cache_arbiter_rr
  import cache_arb_pkg::*;
#(
  parameter int unsigned N_CLIENTS  = 2,
  parameter int unsigned s_offset   = 5,
  parameter int unsigned s_index    = 3,
  parameter int unsigned s_mask     = 2 ** s_offset,
  parameter int unsigned s_line     = 8 * s_mask,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [N_CLIENTS-1:0]                 cl_read,
  input  logic [N_CLIENTS-1:0]                 cl_write,
  input  logic [N_CLIENTS-1:0][ADDR_W-1:0]     cl_address,
  input  logic [N_CLIENTS-1:0][s_line-1:0]     cl_wdata,
  output logic [N_CLIENTS-1:0]                 cl_resp,
  output logic [s_line-1:0]                    cl_rdata,
  output logic                                 mem_read,
  output logic                                 mem_write,
  output logic [ADDR_W-1:0]                    mem_address,
  output logic [s_line-1:0]                    mem_wdata,
  input  logic                                 mem_resp,
  input  logic [s_line-1:0]                    mem_rdata
);

  localparam int unsigned GW        = clog2_min1(N_CLIENTS);
  localparam logic        FIXED_SEL = (FIXED_PRIO != 0);

  // Offset and index bits must fit inside a line address.
  if (N_CLIENTS < 2 || (s_offset + s_index) > ADDR_W) begin : g_param_check
    $error("cache_arbiter_rr: bad N_CLIENTS or address split");
  end

  arb_state_t          state_q, state_d;
  logic [GW-1:0]       grant_q, grant_d;
  logic [GW-1:0]       last_q, last_d;
  logic [N_CLIENTS-1:0] req;
  logic [GW-1:0]       winner;
  logic                any_req;

  assign req      = cl_read | cl_write;
  assign cl_rdata = mem_rdata;

  rr_picker #(
    .N (N_CLIENTS),
    .W (GW)
  ) u_picker (
    .req_i        (req),
    .last_i       (last_q),
    .fixed_prio_i (FIXED_SEL),
    .winner_o     (winner),
    .any_o        (any_req)
  );

  // State, grant and round-robin pointer; last resets to N-1 so client 0 goes first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GW'(N_CLIENTS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // Next state and memory-side forwarding of the granted client.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = '0;
    mem_wdata   = '0;
    cl_resp     = '0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d = winner;
          state_d = BUSY;
        end
      end
      BUSY: begin
        mem_read    = cl_read[grant_q];
        mem_write   = cl_write[grant_q];
        mem_address = cl_address[grant_q];
        mem_wdata   = cl_wdata[grant_q];
        if (mem_resp) begin
          cl_resp[grant_q] = 1'b1;
          last_d           = grant_q;
          state_d          = IDLE;
        end else if (!req[grant_q]) begin
          // Abort: leave last untouched so the client keeps its priority.
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
